// File: rtl/smg_pkg.sv
// Shared types for the seven-segment display arbiter: source IDs, FSM states, data width,
// and helpers for picking a normal source and converting a source ID to its grant vector.
package smg_pkg;

    localparam int SMG_DW = 20;

    typedef enum logic [1:0] {
        SRC_ALERT = 2'd0,
        SRC_A     = 2'd1,
        SRC_B     = 2'd2,
        SRC_NONE  = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALERT = 2'd1,
        SHOW  = 2'd2
    } state_e;

    // A lone requester wins outright; rr only breaks a tie.
    function automatic src_e pick_src(input logic [1:0] req_n, input src_e rr);
        if (req_n == 2'b11) return rr;
        else if (req_n[0])  return SRC_A;
        else                return SRC_B;
    endfunction

    function automatic logic [2:0] src2gnt(input src_e s);
        case (s)
            SRC_ALERT: return 3'b001;
            SRC_A:     return 3'b010;
            SRC_B:     return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/smg_disp_arbiter_if.sv
// Request/data bundle from the three sources plus the arbitrated display-driver outputs.
// The master side drives requests and data; the arbiter uses the slave side.
interface smg_disp_arbiter_if
    import smg_pkg::*;
#(
    parameter int DW = SMG_DW
);
    logic [2:0]    req_i;
    logic [DW-1:0] data0_i;
    logic [DW-1:0] data1_i;
    logic [DW-1:0] data2_i;
    logic [2:0]    gnt_o;
    logic [1:0]    disp_src_o;
    logic [DW-1:0] disp_data_o;
    logic          disp_valid_o;
    logic          disp_blank_o;

    modport master (
        output req_i, data0_i, data1_i, data2_i,
        input  gnt_o, disp_src_o, disp_data_o, disp_valid_o, disp_blank_o
    );

    modport slave (
        input  req_i, data0_i, data1_i, data2_i,
        output gnt_o, disp_src_o, disp_data_o, disp_valid_o, disp_blank_o
    );
endinterface

// File: rtl/smg_slice_timer.sv
// Reloading down-counter: clr loads CYCLES-1, en counts down, expire_o is high on the
// last counted cycle, and the counter reloads automatically when it expires.
module smg_slice_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = LOAD;
        else if (en_i)  cnt_d = expire_o ? LOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= LOAD;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/smg_disp_arbiter.sv
// Display-driver arbiter: the alert source preempts, sources 1/2 share time slices round-robin.
// Data path has one cycle of latency; the SMG_ALERT_BLINK_EN build adds blink blanking.
module smg_disp_arbiter
    import smg_pkg::*;
#(
    parameter int DW           = SMG_DW,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic             clk,
    input  logic             rst,
    smg_disp_arbiter_if.slave bus
);
    if (HOLD_CYCLES < 2 || BLINK_CYCLES < 2) begin : g_param_chk
        $error("smg_disp_arbiter: HOLD_CYCLES and BLINK_CYCLES must be >= 2");
    end

    state_e        state_q, state_d;
    src_e          src_q, src_d, rr_q, rr_d, other;
    logic [2:0]    gnt_q, gnt_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic          disp_valid_q, disp_valid_d;
    logic          own_req, oth_req;
    logic          slice_clr, slice_en, slice_exp;

    assign slice_en = (state_q == SHOW);

    smg_slice_timer #(.CYCLES(HOLD_CYCLES)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (slice_clr),
        .en_i     (slice_en),
        .expire_o (slice_exp)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        rr_d      = rr_q;
        slice_clr = (state_q != SHOW);
        other     = (src_q == SRC_A) ? SRC_B : SRC_A;
        own_req   = (src_q == SRC_A) ? bus.req_i[1] : bus.req_i[2];
        oth_req   = (src_q == SRC_A) ? bus.req_i[2] : bus.req_i[1];

        case (state_q)
            SHOW: begin
                if (bus.req_i[0]) begin
                    // A slice that expires under the alert still counts as completed.
                    state_d = ALERT;
                    src_d   = SRC_ALERT;
                    if (slice_exp && oth_req) rr_d = other;
                end else if (!own_req) begin
                    if (oth_req) begin
                        src_d     = other;
                        rr_d      = other;
                        slice_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                        src_d   = SRC_NONE;
                    end
                end else if (slice_exp && oth_req) begin
                    src_d = other;
                    rr_d  = other;
                end
            end
            default: begin
                if (bus.req_i[0]) begin
                    state_d = ALERT;
                    src_d   = SRC_ALERT;
                end else if (|bus.req_i[2:1]) begin
                    state_d = SHOW;
                    src_d   = pick_src(bus.req_i[2:1], rr_q);
                    rr_d    = src_d;
                end else begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                end
            end
        endcase

        gnt_d = src2gnt(src_d);

        disp_data_d = disp_data_q;
        case (src_q)
            SRC_ALERT: disp_data_d = bus.data0_i;
            SRC_A:     disp_data_d = bus.data1_i;
            SRC_B:     disp_data_d = bus.data2_i;
            default:   disp_data_d = disp_data_q;
        endcase
        disp_valid_d = (src_q != SRC_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_NONE;
            rr_q         <= SRC_A;
            gnt_q        <= 3'b000;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.disp_src_o   = src_q;
    assign bus.disp_data_o  = disp_data_q;
    assign bus.disp_valid_o = disp_valid_q;

`ifdef SMG_ALERT_BLINK_EN
    logic blink_exp;
    logic disp_blank_q, disp_blank_d;

    smg_slice_timer #(.CYCLES(BLINK_CYCLES)) u_blink (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != ALERT),
        .en_i     (state_q == ALERT),
        .expire_o (blink_exp)
    );

    always_comb begin
        disp_blank_d = 1'b0;
        if (state_d == ALERT) disp_blank_d = blink_exp ? ~disp_blank_q : disp_blank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) disp_blank_q <= 1'b0;
        else     disp_blank_q <= disp_blank_d;
    end

    assign bus.disp_blank_o = disp_blank_q;
`else
    assign bus.disp_blank_o = 1'b0;
`endif
endmodule

// File: tb/tb_smg_disp_arbiter.sv
// Directed bench for smg_disp_arbiter with HOLD_CYCLES=8, BLINK_CYCLES=4.
module tb_smg_disp_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smg_disp_arbiter_if #(.DW(20)) bus ();

    smg_disp_arbiter #(.DW(20), .HOLD_CYCLES(8), .BLINK_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] data_of(input logic [2:0] g);
        case (g)
            3'b001:  return bus.data0_i;
            3'b010:  return bus.data1_i;
            default: return bus.data2_i;
        endcase
    endfunction

    logic [2:0]  exp_g, prev_g;
    logic        exp_bl;
    logic [19:0] new_d0;

    initial begin
        bus.req_i   = 3'b111;
        bus.data0_i = 20'hAAAAA;
        bus.data1_i = 20'h00012;
        bus.data2_i = 20'h00034;
        rst = 1'b1;

        // Reset with every request asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt",   bus.gnt_o,        3'b000);
            chk("rst_src",   bus.disp_src_o,   2'd3);
            chk("rst_data",  bus.disp_data_o,  20'h0);
            chk("rst_valid", bus.disp_valid_o, 1'b0);
            chk("rst_blank", bus.disp_blank_o, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", bus.gnt_o,      3'b001);
        chk("post_rst_src", bus.disp_src_o, 2'd0);
        tick();
        chk("post_rst_data",  bus.disp_data_o,  20'hAAAAA);
        chk("post_rst_valid", bus.disp_valid_o, 1'b1);

        // Round-robin slicing, source 1 first
        bus.req_i = 3'b110;
        prev_g = 3'b001;
        for (int i = 0; i < 32; i++) begin
            tick();
            exp_g = (((i / 8) % 2) == 0) ? 3'b010 : 3'b100;
            chk("rr_gnt",  bus.gnt_o,       exp_g);
            chk("rr_src",  bus.disp_src_o,  (exp_g == 3'b010) ? 2'd1 : 2'd2);
            chk("rr_data", bus.disp_data_o, data_of(prev_g));
            prev_g = exp_g;
        end

        // Alert preempts source 1 at slice cycle 3
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pre_alert_gnt", bus.gnt_o, 3'b010);
        end
        bus.req_i = 3'b111;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 4) bus.req_i = 3'b110;
            exp_g = (i < 5) ? 3'b001 : (i < 13) ? 3'b010 : 3'b100;
            chk("preempt_gnt", bus.gnt_o, exp_g);
        end

        // Source 2 drops at slice cycle 2 while source 1 requests
        tick();
        tick();
        bus.req_i = 3'b010;
        tick();
        chk("drop_switch_gnt", bus.gnt_o, 3'b010);
        bus.req_i = 3'b110;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_g = (i < 7) ? 3'b010 : 3'b100;
            chk("drop_restart_gnt", bus.gnt_o, exp_g);
        end
        tick();
        bus.req_i = 3'b000;
        tick();
        chk("idle_gnt",   bus.gnt_o,        3'b000);
        chk("idle_src",   bus.disp_src_o,   2'd3);
        chk("idle_valid", bus.disp_valid_o, 1'b1);
        tick();
        chk("idle_valid2", bus.disp_valid_o, 1'b0);
        chk("idle_hold",   bus.disp_data_o,  20'h00034);

        // Alert on the expiry cycle of source 1; rr must still advance to source 2
        bus.req_i = 3'b110;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_g = (i < 8) ? 3'b100 : 3'b010;
            chk("sim_rr_gnt", bus.gnt_o, exp_g);
        end
        bus.req_i = 3'b111;
        tick();
        chk("sim_alert_gnt", bus.gnt_o, 3'b001);
        bus.req_i = 3'b110;
        tick();
        chk("sim_after_gnt", bus.gnt_o, 3'b100);

        // Alert held for 20 cycles: blink and live data tracking
        bus.req_i = 3'b111;
        new_d0 = 20'h5A5A5;
        for (int j = 0; j < 20; j++) begin
            tick();
`ifdef SMG_ALERT_BLINK_EN
            exp_bl = ((j / 4) % 2) == 1;
`else
            exp_bl = 1'b0;
`endif
            chk("blink_gnt",   bus.gnt_o,        3'b001);
            chk("blink_blank", bus.disp_blank_o, exp_bl);
            chk("blink_valid", bus.disp_valid_o, 1'b1);
            if (j == 11) chk("live_data", bus.disp_data_o, new_d0);
            if (j == 10) bus.data0_i = new_d0;
            if (j == 19) bus.req_i = 3'b110;
        end
        tick();
        chk("blink_exit_blank", bus.disp_blank_o, 1'b0);
        chk("blink_exit_gnt",   bus.gnt_o,        3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
